// File: rtl/dbg_ctrl_pkg.sv
// Shared types and dcsr.cause encodings for the per-hart debug-mode controller.
package dbg_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DEBUG = 2'd1,
        STEP  = 2'd2
    } dbg_state_e;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_TRIGGER   = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

endpackage

// File: rtl/debug_hart_fsm.sv
// One hart's RUN/DEBUG/STEP controller: debug_mode flag, entry pulse, dpc and dcsr.cause capture.
module debug_hart_fsm
    import dbg_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            debug_req_i,
    input  logic            ebreak_i,
    input  logic            step_i,
    input  logic            instr_retire_i,
    input  logic            dret_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            debug_mode_q,
    output logic            enter_debug_o,
    output logic [XLEN-1:0] dpc_o,
    output logic [2:0]      dcause_o
);

    localparam dbg_state_e RST_STATE = RESET_HALTED ? DEBUG : RUN;
    localparam logic [2:0] RST_CAUSE = RESET_HALTED ? CAUSE_RESETHALT : CAUSE_NONE;
    localparam logic       RST_MODE  = RESET_HALTED;

    dbg_state_e state_r;
    logic       trig_s;
    logic [2:0] trig_cause_s;

    // Entry trigger and its cause; retirement only counts while single-stepping.
    always_comb begin
        trig_s       = 1'b0;
        trig_cause_s = CAUSE_NONE;
        if (ebreak_i) begin
            trig_s       = 1'b1;
            trig_cause_s = CAUSE_EBREAK;
        end else if (debug_req_i) begin
            trig_s       = 1'b1;
            trig_cause_s = CAUSE_HALTREQ;
        end else if (instr_retire_i && (state_r == STEP)) begin
            trig_s       = 1'b1;
            trig_cause_s = CAUSE_STEP;
        end else begin
            trig_s       = 1'b0;
            trig_cause_s = CAUSE_NONE;
        end
    end

    // Debug state machine with registered outputs.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= RST_STATE;
            debug_mode_q  <= RST_MODE;
            enter_debug_o <= 1'b0;
            dpc_o         <= {XLEN{1'b0}};
            dcause_o      <= RST_CAUSE;
        end else begin
            case (state_r)
                RUN, STEP: begin
                    if (trig_s) begin
                        state_r       <= DEBUG;
                        debug_mode_q  <= 1'b1;
                        enter_debug_o <= 1'b1;
                        dpc_o         <= pc_i;
                        dcause_o      <= trig_cause_s;
                    end else begin
                        enter_debug_o <= 1'b0;
                    end
                end
                DEBUG: begin
                    // Halt sources are ignored here; dpc and cause hold until the next entry.
                    enter_debug_o <= 1'b0;
                    if (dret_i) begin
                        state_r      <= step_i ? STEP : RUN;
                        debug_mode_q <= 1'b0;
                    end else begin
                        debug_mode_q <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= RUN;
                    debug_mode_q  <= 1'b0;
                    enter_debug_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debug_mode_ctrl.sv
// Per-hart debug-mode controller array; packs per-hart slices and reports all-halted.
module debug_mode_ctrl
    import dbg_ctrl_pkg::*;
#(
    parameter int unsigned NUM_HARTS    = 1,
    parameter int unsigned XLEN         = 64,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic [NUM_HARTS-1:0]      debug_req_i,
    input  logic [NUM_HARTS-1:0]      ebreak_i,
    input  logic [NUM_HARTS-1:0]      step_i,
    input  logic [NUM_HARTS-1:0]      instr_retire_i,
    input  logic [NUM_HARTS-1:0]      dret_i,
    input  logic [NUM_HARTS*XLEN-1:0] pc_i,
    output logic [NUM_HARTS-1:0]      debug_mode_q,
    output logic [NUM_HARTS-1:0]      enter_debug_o,
    output logic [NUM_HARTS*XLEN-1:0] dpc_o,
    output logic [NUM_HARTS*3-1:0]    dcause_o,
    output logic                      halted_o
);

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
        debug_hart_fsm #(
            .XLEN         (XLEN),
            .RESET_HALTED (RESET_HALTED)
        ) u_hart (
            .clk            (clk),
            .rst_i          (rst_i),
            .debug_req_i    (debug_req_i[g]),
            .ebreak_i       (ebreak_i[g]),
            .step_i         (step_i[g]),
            .instr_retire_i (instr_retire_i[g]),
            .dret_i         (dret_i[g]),
            .pc_i           (pc_i[g*XLEN +: XLEN]),
            .debug_mode_q   (debug_mode_q[g]),
            .enter_debug_o  (enter_debug_o[g]),
            .dpc_o          (dpc_o[g*XLEN +: XLEN]),
            .dcause_o       (dcause_o[g*3 +: 3])
        );
    end

    assign halted_o = &debug_mode_q;

endmodule
